// File: rtl/a2b_pkg.sv
// Shared constants and types for the 2-share A2B sequencer: widths, pool layout, FSM states.
package a2b_pkg;
  localparam int K       = 16;
  localparam int RND_W   = 32;
  localparam int RND_TOT = 5 * K - 3;
  localparam int NWORDS  = (RND_TOT + RND_W - 1) / RND_W;
  localparam int WCNT_W  = $clog2(NWORDS + 1);

  // Slice offsets of each randomness field inside the pool.
  localparam int R0_LSB  = 0;
  localparam int R1_LSB  = K;
  localparam int RXY_LSB = 2 * K;
  localparam int RXC_LSB = 3 * K - 1;
  localparam int RYC_LSB = 4 * K - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_LOAD  = 2'd2,
    ST_BUSY  = 2'd3
  } state_e;
endpackage

// File: rtl/a2b_share_sequencer_if.sv
// Bus bundle for the A2B sequencer: share input, TRNG stream, converter link, result output.
interface a2b_share_sequencer_if;
  import a2b_pkg::*;

  // Every valid/ready pair: a transfer happens on a rising clock edge where both are high;
  // the sender holds data stable while valid is high and ready is low.
  logic           in_valid_i;
  logic           in_ready_o;
  logic [K-1:0]   a0_i;
  logic [K-1:0]   a1_i;

  logic           rnd_valid_i;
  logic           rnd_ready_o;
  logic [RND_W-1:0] rnd_i;

  logic           conv_start_o;
  logic [K-1:0]   conv_a0_o;
  logic [K-1:0]   conv_a1_o;
  logic [K-1:0]   conv_r0_o;
  logic [K-1:0]   conv_r1_o;
  logic [K-2:0]   conv_rxy_o;
  logic [K-2:0]   conv_rxc_o;
  logic [K-2:0]   conv_ryc_o;
  logic           conv_finish_i;
  logic [K-1:0]   conv_b0_i;
  logic [K-1:0]   conv_b1_i;

  logic           out_valid_o;
  logic           out_ready_i;
  logic [K-1:0]   b0_o;
  logic [K-1:0]   b1_o;

  logic           busy_o;
  logic           rnd_err_o;
  state_e         dbg_state_o;

  modport slave (
    input  in_valid_i, a0_i, a1_i, rnd_valid_i, rnd_i,
           conv_finish_i, conv_b0_i, conv_b1_i, out_ready_i,
    output in_ready_o, rnd_ready_o, conv_start_o, conv_a0_o, conv_a1_o,
           conv_r0_o, conv_r1_o, conv_rxy_o, conv_rxc_o, conv_ryc_o,
           out_valid_o, b0_o, b1_o, busy_o, rnd_err_o, dbg_state_o
  );

  modport master (
    output in_valid_i, a0_i, a1_i, rnd_valid_i, rnd_i,
           conv_finish_i, conv_b0_i, conv_b1_i, out_ready_i,
    input  in_ready_o, rnd_ready_o, conv_start_o, conv_a0_o, conv_a1_o,
           conv_r0_o, conv_r1_o, conv_rxy_o, conv_rxc_o, conv_ryc_o,
           out_valid_o, b0_o, b1_o, busy_o, rnd_err_o, dbg_state_o
  );
endinterface

// File: rtl/a2b_rnd_pool.sv
// Randomness pool: packs TRNG words into RND_TOT bits, counts words, optional repetition test.
// Optional health check enabled by defining A2B_RND_HEALTH_EN.
module a2b_rnd_pool
  import a2b_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rnd_valid_i,
  input  logic [RND_W-1:0]   rnd_i,
  input  logic               consume_i,
  output logic               rnd_ready_o,
  output logic               full_o,
  output logic [RND_TOT-1:0] pool_o,
  output logic               rnd_err_o
);
  logic [WCNT_W-1:0]  wcnt_q;
  logic [RND_TOT-1:0] pool_q;
  logic               take;
  logic               store;

  assign rnd_ready_o = (wcnt_q < WCNT_W'(NWORDS));
  assign full_o      = (wcnt_q == WCNT_W'(NWORDS));
  assign take        = rnd_valid_i & rnd_ready_o;
  assign pool_o      = pool_q;

`ifdef A2B_RND_HEALTH_EN
  logic [RND_W-1:0] prev_q;
  logic             err_q;
  logic             repeat_word;

  // A word identical to the last one taken is swallowed; prev starts at 0.
  assign repeat_word = (rnd_i == prev_q);
  assign store       = take & ~repeat_word;
  assign rnd_err_o   = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else if (take) begin
      prev_q <= rnd_i;
      if (repeat_word) err_q <= 1'b1;
    end
  end
`else
  assign store     = take;
  assign rnd_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q <= '0;
    end else if (consume_i) begin
      wcnt_q <= '0;
    end else if (store) begin
      wcnt_q <= wcnt_q + 1'b1;
    end
  end

  // Word j lands in pool[j*RND_W +: RND_W]; bits past RND_TOT-1 are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pool_q <= '0;
    end else if (store) begin
      for (int i = 0; i < RND_TOT; i++) begin
        if (wcnt_q == WCNT_W'(i / RND_W)) pool_q[i] <= rnd_i[i % RND_W];
      end
    end
  end
endmodule

// File: rtl/a2b_share_sequencer.sv
// Feeds the 2-share A2B converter with operands and fresh randomness and drains its result.
// Optional randomness repetition test enabled by defining A2B_RND_HEALTH_EN.
module a2b_share_sequencer
  import a2b_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  a2b_share_sequencer_if.slave  bus
);
  state_e             state_q, state_d;
  logic               pool_full;
  logic [RND_TOT-1:0] pool;
  logic               in_ready;
  logic               accept;

  logic [K-1:0] conv_a0_q, conv_a1_q, conv_r0_q, conv_r1_q;
  logic [K-2:0] conv_rxy_q, conv_rxc_q, conv_ryc_q;
  logic [K-1:0] b0_q, b1_q;
  logic         out_valid_q;

  a2b_rnd_pool u_pool (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rnd_valid_i (bus.rnd_valid_i),
    .rnd_i       (bus.rnd_i),
    .consume_i   (accept),
    .rnd_ready_o (bus.rnd_ready_o),
    .full_o      (pool_full),
    .pool_o      (pool),
    .rnd_err_o   (bus.rnd_err_o)
  );

  // A pending result blocks acceptance, so a job never starts in a result-handshake cycle.
  assign in_ready = (state_q == ST_IDLE) & pool_full & ~out_valid_q;
  assign accept   = in_ready & bus.in_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_BUSY;
      ST_BUSY:  if (bus.conv_finish_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operands and randomness are frozen at acceptance and held until the next one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conv_a0_q  <= '0;
      conv_a1_q  <= '0;
      conv_r0_q  <= '0;
      conv_r1_q  <= '0;
      conv_rxy_q <= '0;
      conv_rxc_q <= '0;
      conv_ryc_q <= '0;
    end else if (accept) begin
      conv_a0_q  <= bus.a0_i;
      conv_a1_q  <= bus.a1_i;
      conv_r0_q  <= pool[R0_LSB  +: K];
      conv_r1_q  <= pool[R1_LSB  +: K];
      conv_rxy_q <= pool[RXY_LSB +: K-1];
      conv_rxc_q <= pool[RXC_LSB +: K-1];
      conv_ryc_q <= pool[RYC_LSB +: K-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      b0_q        <= '0;
      b1_q        <= '0;
      out_valid_q <= 1'b0;
    end else if ((state_q == ST_BUSY) && bus.conv_finish_i) begin
      b0_q        <= bus.conv_b0_i;
      b1_q        <= bus.conv_b1_i;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.conv_start_o = (state_q == ST_START);
  assign bus.conv_a0_o    = conv_a0_q;
  assign bus.conv_a1_o    = conv_a1_q;
  assign bus.conv_r0_o    = conv_r0_q;
  assign bus.conv_r1_o    = conv_r1_q;
  assign bus.conv_rxy_o   = conv_rxy_q;
  assign bus.conv_rxc_o   = conv_rxc_q;
  assign bus.conv_ryc_o   = conv_ryc_q;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.b0_o         = b0_q;
  assign bus.b1_o         = b1_q;
  assign bus.busy_o       = (state_q != ST_IDLE);
  assign bus.dbg_state_o  = state_q;
endmodule

// File: tb/tb_a2b_share_sequencer.sv
// Bench for a2b_share_sequencer with a behavioural converter and a result scoreboard.
module tb_a2b_share_sequencer;
  import a2b_pkg::*;

  localparam int LAT = 5;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  int   start_cnt = 0;
  logic [31:0] exp_q[$];

  a2b_share_sequencer_if bus ();

  a2b_share_sequencer dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  // driver tasks
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.rnd_valid_i = 1'b1;
    bus.rnd_i       = w;
    @(negedge clk);
    while (!bus.rnd_ready_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.rnd_ready_o) fail_timeout("rnd_handshake");
    @(posedge clk); #1;
    bus.rnd_valid_i = 1'b0;
  endtask

  task automatic send_job(input logic [K-1:0] a0, input logic [K-1:0] a1,
                          input logic [K-1:0] exp_sum, input logic [K-1:0] exp_r0);
    int n;
    n = 0;
    exp_q.push_back({exp_r0, exp_sum});
    @(posedge clk); #1;
    bus.in_valid_i = 1'b1;
    bus.a0_i       = a0;
    bus.a1_i       = a1;
    @(negedge clk);
    while (!bus.in_ready_o && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready_o) fail_timeout("in_handshake");
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("start_after_accept", 32'(bus.conv_start_o), 32'd1);
    @(negedge clk);
    chk("start_one_cycle_busy", {30'd0, bus.conv_start_o, bus.busy_o}, 32'b01);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) fail_timeout("result_drain");
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid_o && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!bus.out_valid_o) fail_timeout("out_valid");
  endtask

  // behavioural converter: b1 = r0 mask, b0 = (a0+a1) ^ r0
  initial begin : conv_model
    logic [K-1:0] ma0, ma1, mr;
    bit ok;
    bus.conv_finish_i = 1'b0;
    bus.conv_b0_i     = '0;
    bus.conv_b1_i     = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.conv_start_o) begin
        @(negedge clk);
        ma0 = bus.conv_a0_o;
        ma1 = bus.conv_a1_o;
        mr  = bus.conv_r0_o;
        ok  = !rst;
        repeat (LAT) begin
          @(negedge clk);
          if (rst) ok = 1'b0;
        end
        if (ok) begin
          bus.conv_finish_i = 1'b1;
          bus.conv_b1_i     = mr;
          bus.conv_b0_i     = (ma0 + ma1) ^ mr;
          @(negedge clk);
          bus.conv_finish_i = 1'b0;
        end
      end
    end
  end

  initial begin : start_counter
    forever begin
      @(negedge clk);
      if (bus.conv_start_o) start_cnt++;
    end
  end

  // scoreboard monitor
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL result_unexpected: got b0^b1=0x%0h, expected no result", bus.b0_o ^ bus.b1_o);
        end else begin
          e = exp_q.pop_front();
          chk("result_xor", 32'(bus.b0_o ^ bus.b1_o), {16'd0, e[15:0]});
          chk("result_b1", 32'(bus.b1_o), {16'd0, e[31:16]});
        end
      end
    end
  end

  initial begin : stimulus
    bus.in_valid_i  = 1'b0;
    bus.a0_i        = '0;
    bus.a1_i        = '0;
    bus.rnd_valid_i = 1'b0;
    bus.rnd_i       = '0;
    bus.out_ready_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_flags", {26'd0, bus.busy_o, bus.out_valid_o, bus.in_ready_o,
        bus.conv_start_o, bus.rnd_err_o, bus.rnd_ready_o}, 32'b000001);
    chk("reset_state", 32'(bus.dbg_state_o), 32'(ST_IDLE));
    chk("reset_conv_a0", 32'(bus.conv_a0_o), 32'd0);
    chk("reset_b0", 32'(bus.b0_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: pool bit mapping and single start pulse
    send_word(32'hDEADBEEF);
    send_word(32'h01234567);
    send_word(32'h89ABCDEF);
    start_cnt = 0;
    send_job(16'h1234, 16'h0000, 16'h1234, 16'hBEEF);
    chk("conv_a0", 32'(bus.conv_a0_o), 32'h1234);
    chk("conv_a1", 32'(bus.conv_a1_o), 32'h0000);
    chk("conv_r0", 32'(bus.conv_r0_o), 32'hBEEF);
    chk("conv_r1", 32'(bus.conv_r1_o), 32'hDEAD);
    chk("conv_rxy", 32'(bus.conv_rxy_o), 32'h4567);
    chk("conv_rxc", 32'(bus.conv_rxc_o), 32'h0246);
    chk("conv_ryc", 32'(bus.conv_ryc_o), 32'h37BC);
    wait_valid();
    chk("start_count", 32'(start_cnt), 32'd1);

    // 3: stalled result blocks the next job and stays stable
    send_word(32'h13572468);
    send_word(32'h24681357);
    send_word(32'h0BADF00D);
    fork
      send_job(16'h8000, 16'h8000, 16'h0000, 16'h2468);
      begin
        bit ok;
        ok = 1'b1;
        repeat (6) begin
          @(negedge clk);
          if (bus.conv_start_o || !bus.out_valid_o || bus.in_ready_o ||
              (bus.b0_o ^ bus.b1_o) !== 16'h1234 || bus.b1_o !== 16'hBEEF) ok = 1'b0;
        end
        chk("hold_while_stalled", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.out_ready_i = 1'b1;
      end
    join
    wait_drain();

    // 2: partial pool keeps in_ready low until the last word
    send_word(32'h0F1E2D3C);
    send_word(32'h4B5A6978);
    fork
      send_job(16'h1234, 16'h4321, 16'h5555, 16'h2D3C);
      begin
        bit ok;
        ok = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if (bus.in_ready_o) ok = 1'b0;
        end
        chk("in_ready_low_partial_pool", 32'(ok), 32'd1);
        send_word(32'h8796A5B4);
      end
    join
    wait_drain();

    // 4: modular wrap-around
    send_word(32'h11112222);
    send_word(32'h33334444);
    send_word(32'h55556666);
    send_job(16'hFFFF, 16'h0001, 16'h0000, 16'h2222);
    wait_drain();

    // 5: reset while converting
    send_word(32'h6A6B6C6D);
    send_word(32'h7A7B7C7D);
    send_word(32'h0E0F1011);
    send_job(16'h0AAA, 16'h0555, 16'h0FFF, 16'h6C6D);
    @(negedge clk);
    chk("busy_before_reset", 32'(bus.busy_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midreset_flags", {28'd0, bus.busy_o, bus.conv_start_o, bus.out_valid_o, bus.in_ready_o}, 32'd0);
    chk("midreset_conv", {bus.conv_a0_o, bus.conv_r0_o}, 32'd0);
    chk("midreset_ryc", 32'(bus.conv_ryc_o), 32'd0);
    chk("midreset_b0", 32'(bus.b0_o), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("pool_empty_after_reset", {30'd0, bus.rnd_ready_o, bus.in_ready_o}, 32'b10);
    send_word(32'h10203040);
    send_word(32'h50607080);
    send_word(32'h90A0B0C0);
    send_job(16'h00FF, 16'h0F00, 16'h0FFF, 16'h3040);
    wait_drain();

`ifdef A2B_RND_HEALTH_EN
    // 6: repeated TRNG word is dropped and flagged
    send_word(32'hA5A5A5A5);
    send_word(32'hA5A5A5A5);
    @(negedge clk);
    chk("rnd_err_set", 32'(bus.rnd_err_o), 32'd1);
    send_word(32'h5A5A5A5A);
    @(negedge clk);
    chk("pool_not_full_after_repeat", 32'(bus.in_ready_o), 32'd0);
    send_word(32'h3C3C3C3C);
    @(negedge clk);
    chk("pool_full_after_third", 32'(bus.in_ready_o), 32'd1);
    send_job(16'h0001, 16'h0002, 16'h0003, 16'hA5A5);
    wait_drain();
    chk("rnd_err_sticky", 32'(bus.rnd_err_o), 32'd1);
`else
    chk("rnd_err_tied_low", 32'(bus.rnd_err_o), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
